// File: rtl/pipe_addsub.sv
// Pipelined ripple-carry adder/subtractor. One SLICE-bit slice is resolved
// per stage and the carry is registered between stages, so the critical path
// is one slice wide whatever WIDTH is. WIDTH must be a multiple of SLICE.
// Stage k holds the operand slices above k (input skew) and the result
// slices at and below k (output deskew). The whole pipeline advances together
// on en = ~out_valid | out_ready, and bubbles are not squeezed out.
// Optional build macro ADDSUB_SAT_EN: on signed overflow the final stage
// replaces the result with the signed saturation value. Without it the result
// wraps modulo 2^WIDTH.
module pipe_addsub #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);
  localparam int STAGES = WIDTH / SLICE;

  logic              en;
  logic [STAGES:1]   vld_pipe;
  logic [WIDTH-1:0]  fin_sum;
  logic              fin_c;
  logic              fin_ovf;
  logic [WIDTH-1:0]  sum_q;
  logic              c_q;
  logic              ovf_q;

  // Single global advance: everything moves unless the output is stalled.
  assign en       = ~vld_pipe[STAGES] | out_ready;
  assign in_ready = en;

  // Valid shift register; clr wins over advance, the output handshake of the
  // same cycle has already completed by the time the bits clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else if (clr) begin
      vld_pipe <= '0;
    end else if (en) begin
      vld_pipe[1] <= in_valid;
      for (int i = 2; i <= STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits still to be consumed, and result bits resolved so far.
    localparam int AW = WIDTH - k*SLICE;
    localparam int LW = (k+1)*SLICE;

    logic [AW-1:0]    a_in;
    logic [AW-1:0]    b_in;
    logic             ci;
    logic [SLICE-1:0] s_sl;
    logic             co;
    logic [LW-1:0]    s_cat;

    if (k == 0) begin : g_src
      // B is inverted and carry forced to 1 for subtraction; c_in ignored.
      assign a_in  = a;
      assign b_in  = sub ? ~b : b;
      assign ci    = sub | c_in;
      assign s_cat = s_sl;
    end else begin : g_src
      assign a_in  = g_stage[k-1].g_fwd.a_r;
      assign b_in  = g_stage[k-1].g_fwd.b_r;
      assign ci    = g_stage[k-1].g_fwd.c_r;
      assign s_cat = {s_sl, g_stage[k-1].g_fwd.s_r};
    end

    addsub_slice #(.SLICE(SLICE)) u_slice (
      .a  (a_in[SLICE-1:0]),
      .b  (b_in[SLICE-1:0]),
      .ci (ci),
      .s  (s_sl),
      .co (co)
    );

    if (k < STAGES-1) begin : g_fwd
      logic [AW-SLICE-1:0] a_r;
      logic [AW-SLICE-1:0] b_r;
      logic [LW-1:0]       s_r;
      logic                c_r;

      // Stage register: remaining operand slices, partial result, carry.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_r <= '0;
          b_r <= '0;
          s_r <= '0;
          c_r <= 1'b0;
        end else if (en) begin
          a_r <= a_in[AW-1:SLICE];
          b_r <= b_in[AW-1:SLICE];
          s_r <= s_cat;
          c_r <= co;
        end
      end
    end else begin : g_last
      logic ovf_w;

      // Effective operand signs agree but the result sign differs.
      assign ovf_w = (a_in[AW-1] == b_in[AW-1]) && (s_cat[LW-1] != a_in[AW-1]);

`ifdef ADDSUB_SAT_EN
      logic [WIDTH-1:0] sat_v;
      // Positive overflow (sign 0) clamps to max, negative to min.
      assign sat_v   = {a_in[AW-1], {(WIDTH-1){~a_in[AW-1]}}};
      assign fin_sum = ovf_w ? sat_v : s_cat;
`else
      assign fin_sum = s_cat;
`endif
      assign fin_c   = co;
      assign fin_ovf = ovf_w;
    end
  end

  // Final-stage registers drive the outputs directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      c_q   <= 1'b0;
      ovf_q <= 1'b0;
    end else if (en) begin
      sum_q <= fin_sum;
      c_q   <= fin_c;
      ovf_q <= fin_ovf;
    end
  end

  assign out_valid = vld_pipe[STAGES];
  assign sum       = sum_q;
  assign c_out     = c_q;
  assign ovf       = ovf_q;

endmodule

// One SLICE-bit ripple slice: sum and carry-out of a + b + ci.
module addsub_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             ci,
  output logic [SLICE-1:0] s,
  output logic             co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, ci};
endmodule

// File: tb/tb_pipe_addsub.sv
// Bench for pipe_addsub (WIDTH=16, SLICE=4): directed literal cases plus a
// randomized stream checked every cycle against an arithmetic model.
module tb_pipe_addsub;
  localparam int W      = 16;
  localparam int SL     = 4;
  localparam int STAGES = W / SL;

  logic         clk;
  logic         rst_n;
  logic         clr;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;

  pipe_addsub #(.WIDTH(W), .SLICE(SL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_acc = 0;
  int n_hs  = 0;
  int run   = 0;
  int max_run = 0;
  int adv   = 0;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           stamp;
  } ent_t;

  ent_t q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Result of one operation from plain integer arithmetic.
  function automatic ent_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                 input logic tc, input logic ts);
    ent_t         e;
    logic [W-1:0] bb;
    logic [W:0]   full;
    bb   = ts ? ~tb_ : tb_;
    full = {1'b0, ta} + {1'b0, bb} + (W+1)'(ts | tc);
    e.s  = full[W-1:0];
    e.c  = full[W];
    e.o  = (ta[W-1] == bb[W-1]) && (full[W-1] != ta[W-1]);
`ifdef ADDSUB_SAT_EN
    if (e.o) e.s = ta[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    e.stamp = 0;
    return e;
  endfunction

  // Per-cycle compare, sampled mid-cycle. An op accepted at the edge that
  // makes the advance count N is due on the output once N+STAGES-1 is reached.
  always @(negedge clk) begin : compare_p
    logic ev;
    logic en;
    ent_t e;
    if (!rst_n) begin
      q.delete();
      run = 0;
    end else begin
      ev = (q.size() > 0) && ((adv - q[0].stamp + 1) >= STAGES);
      chk("out_valid", out_valid, ev);
      chk("in_ready", in_ready, !ev || out_ready);
      if (ev) begin
        chk("sum", sum, q[0].s);
        chk("c_out", c_out, q[0].c);
        chk("ovf", ovf, q[0].o);
      end
      en = !ev || out_ready;
      if (ev && out_ready) begin
        e = q.pop_front();
        n_hs++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (clr) begin
        q.delete();
      end else if (en) begin
        adv++;
        if (in_valid) begin
          e = model(a, b, c_in, sub);
          e.stamp = adv;
          q.push_back(e);
          n_acc++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(5))
      0:       return '0;
      1:       return {1'b0, {(W-1){1'b1}}};
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  // Single operation into an idle pipe; checks latency and literal results.
  task automatic directed(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tc, input logic ts, input logic [W-1:0] es,
                          input logic ec, input logic eo);
    int lat;
    step();
    a = ta; b = tb_; c_in = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({nm, "_lat"}, lat, STAGES);
    chk({nm, "_sum"}, sum, es);
    chk({nm, "_cout"}, c_out, ec);
    chk({nm, "_ovf"}, ovf, eo);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin : drive
    int h0;
    int a0;
    logic [W-1:0] s_hold;
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; a = '0; b = '0;
    c_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_c_out", c_out, 0);
    chk("rst_ovf", ovf, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    directed("add_basic", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    directed("carry_all", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
`ifdef ADDSUB_SAT_EN
    directed("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    directed("neg_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1);
`else
    directed("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed("neg_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif

    // Back-to-back alternating add/sub: results on consecutive cycles.
    step();
    max_run = 0;
    h0 = n_hs;
    for (int i = 0; i < 8; i++) begin
      a = pick(); b = pick(); c_in = 1'($urandom); sub = 1'(i % 2); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    repeat (8) step();
    chk("b2b_count", n_hs - h0, 8);
    chk("b2b_run", max_run, 8);

    // Backpressure: out_ready low for 5 cycles while streaming.
    h0 = n_hs;
    a0 = n_acc;
    s_hold = '0;
    for (int i = 0; i < 14; i++) begin
      a = pick(); b = pick(); c_in = 1'($urandom); sub = 1'($urandom); in_valid = 1'b1;
      out_ready = !(i >= 5 && i < 10);
      if (i == 6) begin
        @(negedge clk);
        s_hold = sum;
      end
      if (i == 8) begin
        @(negedge clk);
        chk("bp_stall_valid", out_valid, 1);
        chk("bp_stall_sum", sum, s_hold);
      end
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (10) step();
    chk("bp_no_loss", n_hs - h0, n_acc - a0);

    // Flush with three operations in flight and an input in the clr cycle.
    h0 = n_hs;
    for (int i = 0; i < 3; i++) begin
      a = 16'h1000 + W'(i); b = 16'h0101; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
      step();
    end
    clr = 1'b1;
    a = 16'h4444;
    step();
    clr = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("clr_out_valid", out_valid, 0);
    repeat (6) step();
    chk("clr_none_emitted", n_hs - h0, 0);

    // Asynchronous reset between edges with a full pipe.
    for (int i = 0; i < 6; i++) begin
      a = 16'h1234 + W'(i); b = 16'h0001; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
      step();
    end
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_sum", sum, 0);
    chk("arst_c_out", c_out, 0);
    chk("arst_ovf", ovf, 0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_idle", out_valid, 0);

    // Randomized stream with stalls and occasional flushes.
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      a = pick(); b = pick(); c_in = 1'($urandom); sub = 1'($urandom);
      out_ready = ((i % 100) < 50) ? 1'b1 : ($urandom_range(2) != 0);
      clr       = ($urandom_range(49) == 0);
      step();
    end
    clr = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (10) step();
    chk("drain_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
